// File: rtl/fpu_pkg.sv
// Shared FPU definitions: mantissa widths and the sequential multiplier FSM encoding.
package fpu_pkg;

  localparam int FP32_MANT_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/rca_adder.sv
// Ripple-carry adder row: a half adder in bit 0 followed by WIDTH-1 full adder cells.
module rca_adder #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:1] carry;

  assign sum[0]   = a[0] ^ b[0];
  assign carry[1] = a[0] & b[0];

  for (genvar i = 1; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mant_mul_seq.sv
// Iterative shift-and-add mantissa multiplier: one partial product per cycle through a
// single adder row, valid/ready on both sides, one operation in flight.
module mant_mul_seq
  import fpu_pkg::*;
#(
  parameter int WIDTH = FP32_MANT_W,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic [WIDTH-1:0] acc_hi_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] row_sum;
  logic             row_cout;

  assign addend = mplr_q[0] ? mcand_q : '0;

  rca_adder #(.WIDTH(WIDTH)) u_row (
    .a    (acc_hi_q),
    .b    (addend),
    .sum  (row_sum),
    .cout (row_cout)
  );

  always_comb begin
    // NOTE: next state defaults to the current one before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_hi_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (in_valid) begin
          mcand_q  <= a;
          mplr_q   <= b;
          acc_hi_q <= '0;
          cnt_q    <= '0;
        end
        // {carry, sum, mplr} >> 1: carry lands in acc_hi MSB, sum LSB enters the multiplier top
        BUSY: begin
          acc_hi_q <= {row_cout, row_sum[WIDTH-1:1]};
          mplr_q   <= {row_sum[0], mplr_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = {acc_hi_q, mplr_q};

endmodule
